// File: rtl/vga_line_reader.sv
// rtl/vga_line_reader.sv - VGA timing generator replaying one buffered grayscale line to the DAC
// Three-stage pipeline: counters -> RAM address -> RAM data -> registered pins.
module vga_line_reader #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [3:0] RDATA,
    output logic [9:0] RADDR,
    output logic       RE,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] L_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] L_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] L_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] L_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] L_VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] L_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    // Flag bundles travel alongside the RAM read: {frame_start, line_start, vs_win, hs_win, de}
    logic [4:0] r_s1_flags;
    logic [4:0] r_s2_flags;

    logic w_active;
    logic w_hs_win;
    logic w_vs_win;
    logic w_line_start;
    logic w_frame_start;
    logic w_h_wrap;

    assign w_active      = (r_h_cnt < L_H_ACTIVE) && (r_v_cnt < L_V_ACTIVE);
    assign w_hs_win      = (r_h_cnt >= L_HS_FIRST) && (r_h_cnt <= L_HS_LAST);
    assign w_vs_win      = (r_v_cnt >= L_VS_FIRST) && (r_v_cnt <= L_VS_LAST);
    assign w_line_start  = w_active && (r_h_cnt == 10'd0);
    assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    assign w_h_wrap      = (r_h_cnt == L_H_LAST);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= 10'd0;
            r_v_cnt     <= 10'd0;
            RE          <= 1'b0;
            RADDR       <= 10'd0;
            r_s1_flags  <= 5'd0;
            r_s2_flags  <= 5'd0;
            vga_r       <= 4'd0;
            vga_g       <= 4'd0;
            vga_b       <= 4'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (w_h_wrap) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= (r_v_cnt == L_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end

            RE         <= w_active;
            RADDR      <= w_active ? r_h_cnt : 10'd0;
            r_s1_flags <= {w_frame_start, w_line_start, w_vs_win, w_hs_win, w_active};

            r_s2_flags <= r_s1_flags;

            // RDATA now belongs to the same counter state as r_s2_flags
            vga_r       <= r_s2_flags[0] ? RDATA : 4'd0;
            vga_g       <= r_s2_flags[0] ? RDATA : 4'd0;
            vga_b       <= r_s2_flags[0] ? RDATA : 4'd0;
            de          <= r_s2_flags[0];
            hsync       <= r_s2_flags[1] ? SYNC_POL : ~SYNC_POL;
            vsync       <= r_s2_flags[2] ? SYNC_POL : ~SYNC_POL;
            line_start  <= r_s2_flags[3];
            frame_start <= r_s2_flags[4];
        end
    end

endmodule
